// File: rtl/uart_stream_fifo_if.sv
// Byte-stream valid/ready bundle used for every port pair of uart_stream_fifo.
// The master drives data/valid and the slave drives ready.
interface uart_stream_fifo_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_stream_fifo.sv
// Bidirectional FWFT byte FIFO between the host UART port and the usb_uart pipeline.
// Optional macro UART_STREAM_CRLF_EN expands each LF on the TX path into CR,LF.
module uart_stream_fifo_path #(
    parameter int AW   = 4,
    parameter bit CRLF = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level
);
    localparam int          EW    = CRLF ? 9 : 8;
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [EW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [EW-1:0] head_q, head_d;
    logic          head_valid_q, head_valid_d;
    logic          cr_sent_q, cr_sent_d;
    logic          ready_q, ready_d;
    logic          push, pop, handshake, mem_we, head_flag;
    logic [EW-1:0] in_entry;

    // With CRLF the entry MSB marks an LF that must be preceded by a CR.
    generate
        if (CRLF) begin : g_crlf
            assign in_entry  = {(in_data == 8'h0A), in_data};
            assign head_flag = head_q[EW-1];
        end else begin : g_plain
            assign in_entry  = in_data;
            assign head_flag = 1'b0;
        end
    endgenerate

    always_comb begin
        handshake    = head_valid_q & out_ready;
        pop          = handshake & (~head_flag | cr_sent_q);
        push         = in_valid & ready_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        cr_sent_d    = cr_sent_q;
        mem_we       = 1'b0;
        if (handshake & ~pop) begin
            cr_sent_d = 1'b1;
        end
        // Refill the output register from storage first, else bypass the push.
        if (pop | ~head_valid_q) begin
            cr_sent_d = 1'b0;
            if (wr_ptr_q != rd_ptr_q) begin
                head_d       = mem[rd_ptr_q];
                head_valid_d = 1'b1;
                rd_ptr_d     = rd_ptr_q + 1'b1;
                mem_we       = push;
            end else if (push) begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end else begin
            mem_we = push;
        end
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ready_d = (level_d != DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            cr_sent_q    <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            cr_sent_q    <= cr_sent_d;
            ready_q      <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= in_entry;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = head_valid_q;
    assign out_data  = (head_flag & ~cr_sent_q) ? 8'h0D : head_q[7:0];
    assign level     = level_q;
endmodule

module uart_stream_fifo #(
    parameter int TX_AW = 4,
    parameter int RX_AW = 4
) (
    input  logic               clk_48mhz,
    input  logic               reset_n,
    uart_stream_fifo_if.slave  host_tx,
    uart_stream_fifo_if.master usb_in,
    uart_stream_fifo_if.slave  usb_out,
    uart_stream_fifo_if.master host_rx,
    output logic [TX_AW:0]     tx_level,
    output logic [RX_AW:0]     rx_level
);
`ifdef UART_STREAM_CRLF_EN
    localparam bit TX_CRLF = 1'b1;
`else
    localparam bit TX_CRLF = 1'b0;
`endif

    uart_stream_fifo_path #(.AW(TX_AW), .CRLF(TX_CRLF)) u_tx (
        .clk       (clk_48mhz),
        .rst_n     (reset_n),
        .in_data   (host_tx.data),
        .in_valid  (host_tx.valid),
        .in_ready  (host_tx.ready),
        .out_data  (usb_in.data),
        .out_valid (usb_in.valid),
        .out_ready (usb_in.ready),
        .level     (tx_level)
    );

    uart_stream_fifo_path #(.AW(RX_AW), .CRLF(1'b0)) u_rx (
        .clk       (clk_48mhz),
        .rst_n     (reset_n),
        .in_data   (usb_out.data),
        .in_valid  (usb_out.valid),
        .in_ready  (usb_out.ready),
        .out_data  (host_rx.data),
        .out_valid (host_rx.valid),
        .out_ready (host_rx.ready),
        .level     (rx_level)
    );
endmodule

// File: tb/tb_uart_stream_fifo.sv
// Self-checking bench for uart_stream_fifo: queue-based reference model of both paths.
module tb_uart_stream_fifo;
    localparam int DEPTH = 16;
`ifdef UART_STREAM_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk_48mhz = 1'b0;
    logic       reset_n;
    logic [4:0] tx_level, rx_level;

    uart_stream_fifo_if host_tx ();
    uart_stream_fifo_if usb_in ();
    uart_stream_fifo_if usb_out ();
    uart_stream_fifo_if host_rx ();

    uart_stream_fifo #(.TX_AW(4), .RX_AW(4)) dut (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .host_tx   (host_tx),
        .usb_in    (usb_in),
        .usb_out   (usb_out),
        .host_rx   (host_rx),
        .tx_level  (tx_level),
        .rx_level  (rx_level)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    int vectors = 0;
    int miscompares = 0;

    // Model state: tx_q holds emitted bytes tagged {cr_prefix, byte}; tx_entries counts stored entries.
    logic [8:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_got[$];
    logic [7:0] rx_got[$];
    int         tx_entries;
    bit         run_m;
    bit         last_tx_push, last_rx_push;

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        tx_got.delete();
        rx_got.delete();
        tx_entries = 0;
        run_m = 1'b0;
    endtask

    task automatic idle_inputs();
        host_tx.valid = 1'b0;
        host_tx.data  = 8'h00;
        usb_in.ready  = 1'b0;
        usb_out.valid = 1'b0;
        usb_out.data  = 8'h00;
        host_rx.ready = 1'b0;
    endtask

    // Advance one clock, updating the model from the handshakes that edge performs.
    task automatic cycle();
        bit         tx_push, tx_pop, rx_push, rx_pop;
        logic [7:0] txb, rxb;
        logic [8:0] f;
        tx_push = host_tx.valid && run_m && (tx_entries != DEPTH);
        tx_pop  = usb_in.ready && (tx_q.size() > 0);
        rx_push = usb_out.valid && run_m && (rx_q.size() != DEPTH);
        rx_pop  = host_rx.ready && (rx_q.size() > 0);
        txb = host_tx.data;
        rxb = usb_out.data;
        if (tx_pop) tx_got.push_back(usb_in.data);
        if (rx_pop) rx_got.push_back(host_rx.data);
        @(posedge clk_48mhz);
        #1;
        if (tx_pop) begin
            f = tx_q.pop_front();
            if (!f[8]) tx_entries--;
        end
        if (tx_push) begin
            if (CRLF && txb == 8'h0A) tx_q.push_back({1'b1, 8'h0D});
            tx_q.push_back({1'b0, txb});
            tx_entries++;
        end
        if (rx_pop) void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(rxb);
        last_tx_push = tx_push;
        last_rx_push = rx_push;
        run_m = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk_48mhz);
        #1;
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        model_clear();
        reset_n = 1'b0;
        #5;
        vectors += 8;
        if (tx_level !== 5'd0) begin miscompares++; $display("FAIL reset_tx_level: got %0d want 0", tx_level); end
        if (rx_level !== 5'd0) begin miscompares++; $display("FAIL reset_rx_level: got %0d want 0", rx_level); end
        if (usb_in.valid !== 1'b0) begin miscompares++; $display("FAIL reset_usb_in_valid: got %b want 0", usb_in.valid); end
        if (host_rx.valid !== 1'b0) begin miscompares++; $display("FAIL reset_host_rx_valid: got %b want 0", host_rx.valid); end
        if (host_tx.ready !== 1'b0) begin miscompares++; $display("FAIL reset_host_tx_ready: got %b want 0", host_tx.ready); end
        if (usb_out.ready !== 1'b0) begin miscompares++; $display("FAIL reset_usb_out_ready: got %b want 0", usb_out.ready); end
        if (usb_in.data !== 8'h00) begin miscompares++; $display("FAIL reset_usb_in_data: got %h want 00", usb_in.data); end
        if (host_rx.data !== 8'h00) begin miscompares++; $display("FAIL reset_host_rx_data: got %h want 00", host_rx.data); end
        apply_reset();
        vectors += 2;
        if (host_tx.ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_tx_ready: got %b want 1", host_tx.ready); end
        if (usb_out.ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_rx_ready: got %b want 1", usb_out.ready); end
    endtask

    task automatic test_tx_hold();
        logic [7:0] bytes [3] = '{8'h41, 8'h42, 8'h43};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            host_tx.valid = 1'b1;
            host_tx.data  = bytes[i];
            cycle();
            vectors += 2;
            if (usb_in.valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid[%0d]: got %b want 1", i, usb_in.valid); end
            if (usb_in.data !== 8'h41) begin miscompares++; $display("FAIL hold_data[%0d]: got %h want 41", i, usb_in.data); end
        end
        host_tx.valid = 1'b0;
        cycle();
        vectors += 2;
        if (tx_level !== 5'd3) begin miscompares++; $display("FAIL hold_level: got %0d want 3", tx_level); end
        if (usb_in.data !== 8'h41) begin miscompares++; $display("FAIL hold_data_final: got %h want 41", usb_in.data); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            host_tx.valid = 1'b1;
            host_tx.data  = 8'(i);
            cycle();
        end
        host_tx.data = 8'hAA;
        vectors += 3;
        if (host_tx.ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", host_tx.ready); end
        if (tx_level !== 5'd16) begin miscompares++; $display("FAIL full_level: got %0d want 16", tx_level); end
        if (usb_in.data !== 8'h00) begin miscompares++; $display("FAIL full_head: got %h want 00", usb_in.data); end
        usb_in.ready = 1'b1;
        cycle();
        usb_in.ready  = 1'b0;
        host_tx.valid = 1'b0;
        vectors += 4;
        if (tx_got.size() != 1 || tx_got[0] !== 8'h00) begin miscompares++; $display("FAIL full_popped: got %0d bytes want one 00", tx_got.size()); end
        if (host_tx.ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_after_pop: got %b want 1", host_tx.ready); end
        if (tx_level !== 5'd15) begin miscompares++; $display("FAIL full_level_after_pop: got %0d want 15", tx_level); end
        if (usb_in.data !== 8'h01) begin miscompares++; $display("FAIL full_next_head: got %h want 01", usb_in.data); end
    endtask

    task automatic test_rx_stream();
        int sent = 0;
        int budget = 0;
        apply_reset();
        while (rx_got.size() < 40 && budget < 2000) begin
            usb_out.valid = (sent < 40);
            usb_out.data  = 8'(sent);
            host_rx.ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_rx_push) sent++;
            budget++;
            vectors += 3;
            if (rx_level > 5'd16) begin miscompares++; $display("FAIL rx_level_bound: got %0d want <=16", rx_level); end
            if (rx_level !== 5'(rx_q.size())) begin miscompares++; $display("FAIL rx_level: got %0d want %0d", rx_level, rx_q.size()); end
            if (host_rx.valid !== (rx_q.size() > 0)) begin miscompares++; $display("FAIL rx_valid: got %b want %b", host_rx.valid, rx_q.size() > 0); end
        end
        idle_inputs();
        vectors++;
        if (rx_got.size() != 40) begin miscompares++; $display("FAIL rx_stream_count: got %0d want 40", rx_got.size()); end
        for (int i = 0; i < rx_got.size(); i++) begin
            vectors++;
            if (rx_got[i] !== 8'(i)) begin miscompares++; $display("FAIL rx_order[%0d]: got %h want %h", i, rx_got[i], 8'(i)); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            host_tx.valid = 1'b1;
            host_tx.data  = 8'(8'h60 + i);
            cycle();
        end
        usb_in.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            if (b == 8'h0A) b = 8'h0B;
            host_tx.data = b;
            cycle();
            vectors += 2;
            if (tx_level !== 5'd5) begin miscompares++; $display("FAIL wrap_level[%0d]: got %0d want 5", i, tx_level); end
            if (usb_in.data !== tx_q[0][7:0]) begin miscompares++; $display("FAIL wrap_data[%0d]: got %h want %h", i, usb_in.data, tx_q[0][7:0]); end
        end
        vectors++;
        if (tx_got[0] !== 8'h60 || tx_got[4] !== 8'h64) begin miscompares++; $display("FAIL wrap_prefill: got %h/%h want 60/64", tx_got[0], tx_got[4]); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            host_tx.valid = 1'b1;
            host_tx.data  = 8'(8'h30 + i);
            usb_out.valid = 1'b1;
            usb_out.data  = 8'(8'h50 + i);
            cycle();
        end
        vectors++;
        if (tx_level !== 5'd7) begin miscompares++; $display("FAIL areset_pre_level: got %0d want 7", tx_level); end
        #4;
        reset_n = 1'b0;
        #1;
        vectors += 4;
        if (usb_in.valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b want 0", usb_in.valid); end
        if (tx_level !== 5'd0) begin miscompares++; $display("FAIL areset_tx_level: got %0d want 0", tx_level); end
        if (rx_level !== 5'd0) begin miscompares++; $display("FAIL areset_rx_level: got %0d want 0", rx_level); end
        if (host_tx.ready !== 1'b0) begin miscompares++; $display("FAIL areset_ready: got %b want 0", host_tx.ready); end
        idle_inputs();
        model_clear();
        @(posedge clk_48mhz);
        #1;
        reset_n = 1'b1;
        cycle();
        usb_in.ready  = 1'b1;
        host_rx.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            vectors += 2;
            if (usb_in.valid !== 1'b0) begin miscompares++; $display("FAIL areset_stale_tx[%0d]: got %b want 0", i, usb_in.valid); end
            if (host_rx.valid !== 1'b0) begin miscompares++; $display("FAIL areset_stale_rx[%0d]: got %b want 0", i, host_rx.valid); end
        end
        idle_inputs();
    endtask

    task automatic test_crlf();
        logic [7:0] pushed [3] = '{8'h48, 8'h0A, 8'h49};
        logic [7:0] want[$];
        apply_reset();
        if (CRLF) want = '{8'h48, 8'h0D, 8'h0A, 8'h49};
        else      want = '{8'h48, 8'h0A, 8'h49};
        usb_in.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_tx.valid = 1'b1;
            host_tx.data  = pushed[i];
            cycle();
        end
        host_tx.valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        vectors++;
        if (tx_got.size() != want.size()) begin miscompares++; $display("FAIL crlf_count: got %0d want %0d", tx_got.size(), want.size()); end
        for (int i = 0; i < want.size() && i < tx_got.size(); i++) begin
            vectors++;
            if (tx_got[i] !== want[i]) begin miscompares++; $display("FAIL crlf_byte[%0d]: got %h want %h", i, tx_got[i], want[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            host_tx.valid = 1'($urandom_range(0, 1));
            host_tx.data  = 8'($urandom);
            usb_in.ready  = ($urandom_range(0, 3) == 0);
            usb_out.valid = 1'($urandom_range(0, 1));
            usb_out.data  = 8'($urandom);
            host_rx.ready = ($urandom_range(0, 2) == 0);
            cycle();
            vectors += 6;
            if (tx_level !== 5'(tx_entries)) begin miscompares++; $display("FAIL rand_tx_level[%0d]: got %0d want %0d", i, tx_level, tx_entries); end
            if (rx_level !== 5'(rx_q.size())) begin miscompares++; $display("FAIL rand_rx_level[%0d]: got %0d want %0d", i, rx_level, rx_q.size()); end
            if (usb_in.valid !== (tx_q.size() > 0)) begin miscompares++; $display("FAIL rand_tx_valid[%0d]: got %b want %b", i, usb_in.valid, tx_q.size() > 0); end
            if (host_rx.valid !== (rx_q.size() > 0)) begin miscompares++; $display("FAIL rand_rx_valid[%0d]: got %b want %b", i, host_rx.valid, rx_q.size() > 0); end
            if (host_tx.ready !== (tx_entries != DEPTH)) begin miscompares++; $display("FAIL rand_tx_ready[%0d]: got %b want %b", i, host_tx.ready, tx_entries != DEPTH); end
            if (usb_out.ready !== (rx_q.size() != DEPTH)) begin miscompares++; $display("FAIL rand_rx_ready[%0d]: got %b want %b", i, usb_out.ready, rx_q.size() != DEPTH); end
            if (tx_q.size() > 0) begin
                vectors++;
                if (usb_in.data !== tx_q[0][7:0]) begin miscompares++; $display("FAIL rand_tx_data[%0d]: got %h want %h", i, usb_in.data, tx_q[0][7:0]); end
            end
            if (rx_q.size() > 0) begin
                vectors++;
                if (host_rx.data !== rx_q[0]) begin miscompares++; $display("FAIL rand_rx_data[%0d]: got %h want %h", i, host_rx.data, rx_q[0]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_tx_hold();
        test_full();
        test_rx_stream();
        test_wrap();
        test_async_reset();
        test_crlf();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
